// File: rtl/bypass_pkg.sv
// -----------------------------------------------------------------------------
// bypass_pkg
// Shared types and helpers for the click-free engage/bypass controller.
//   bypass_state_t : sequencing states of the relay/fade FSM
//   gain_width()   : width of the linear gain register for a given ramp length
//   relay_on()     : relay drive decoded from a state
//   is_busy()      : transitional-state decode (anything but BYPASS/ACTIVE)
// -----------------------------------------------------------------------------
package bypass_pkg;

  typedef enum logic [2:0] {
    BYPASS,
    SETTLE_ON,
    FADE_IN,
    ACTIVE,
    FADE_OUT,
    SETTLE_OFF
  } bypass_state_t;

  // The gain runs 0..ramp_samples inclusive, so one bit beyond log2(ramp).
  function automatic int gain_width(input int ramp_samples);
    return $clog2(ramp_samples) + 1;
  endfunction

  // Relay is closed from the start of SETTLE_ON until the fade-out has reached
  // silence; it is open in BYPASS and while the contacts settle on the way out.
  function automatic logic relay_on(input bypass_state_t s);
    return (s == SETTLE_ON) || (s == FADE_IN) || (s == ACTIVE) || (s == FADE_OUT);
  endfunction

  function automatic logic is_busy(input bypass_state_t s);
    return (s != BYPASS) && (s != ACTIVE);
  endfunction

endpackage

// File: rtl/bypass_relay_ctrl_button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronises a raw active-low footswitch and debounces it on sample ticks.
// A new level must differ from the accepted level for DEBOUNCE_SAMPLES
// consecutive ticks; a 1->0 acceptance produces a one-clock press pulse.
// Ports:
//   clk_i    : system clock
//   arst_n_i : asynchronous reset, active low
//   tick_i   : one-clock strobe per audio sample (debounce time base)
//   btn_n_i  : raw button, active low, asynchronous to clk_i
//   press_o  : one-clock pulse on an accepted press (release gives nothing)
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_SAMPLES = 882
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic tick_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int            CW       = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SAMPLES - 1);

  logic          sync_meta;
  logic          sync_lvl;
  logic          stable;
  logic [CW-1:0] cnt;

  // Idle level of the footswitch is high, so the synchroniser resets to 1 to
  // avoid a false press right after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes a shift chain.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_meta <= 1'b1;
      sync_lvl  <= 1'b1;
    end else begin
      sync_meta <= btn_n_i;
      sync_lvl  <= sync_meta;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      stable  <= 1'b1;
      cnt     <= '0;
      press_o <= 1'b0;
    end else begin
      press_o <= 1'b0;
      if (sync_lvl == stable) begin
        cnt <= '0;
      end else if (tick_i) begin
        // The tick that would bring the count to DEBOUNCE_SAMPLES accepts the
        // new level instead of storing the count.
        if (cnt == CNT_LAST) begin
          stable  <= sync_lvl;
          cnt     <= '0;
          press_o <= ~sync_lvl;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bypass_relay_ctrl.sv
// -----------------------------------------------------------------------------
// bypass_relay_ctrl
// Click-free effect engage/bypass controller between the output limiter and
// i2s_core. A debounced footswitch press sequences the bypass relay and a
// linear gain ramp so the relay only switches while the output is silent.
// Ports:
//   clk_i         : system clock
//   arst_n_i      : asynchronous reset, active low
//   sample_tick_i : one-clock strobe per audio sample
//   button_i      : raw footswitch, active low, asynchronous
//   data_i        : limited wet sample (signed), valid on sample_tick_i
//   data_o        : gained sample to i2s_core, registered, held between ticks
//   relay_o       : 1 = effect path engaged, 0 = true bypass
//   effect_on_o   : 1 only in ACTIVE
//   busy_o        : 1 in any state other than BYPASS or ACTIVE
// -----------------------------------------------------------------------------
module bypass_relay_ctrl
  import bypass_pkg::*;
#(
  parameter int DWIDTH           = 24,
  parameter int RAMP_SAMPLES     = 256,
  parameter int SETTLE_SAMPLES   = 441,
  parameter int DEBOUNCE_SAMPLES = 882
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              sample_tick_i,
  input  logic              button_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              relay_o,
  output logic              effect_on_o,
  output logic              busy_o
);

  localparam int            GW          = gain_width(RAMP_SAMPLES);
  localparam int            SHIFT       = GW - 1;
  localparam int            PW          = DWIDTH + GW + 1;
  localparam int            SW          = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [GW-1:0] GAIN_MAX    = GW'(RAMP_SAMPLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);

  logic                 press;
  bypass_state_t        state, state_eff, state_next;
  logic [GW-1:0]        gain, gain_next;
  logic [SW-1:0]        settle_cnt, settle_next;
  logic signed [PW-1:0] product;
  logic [DWIDTH-1:0]    scaled;

  button_debouncer #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_debouncer (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .tick_i  (sample_tick_i),
    .btn_n_i (button_i),
    .press_o (press)
  );

  // Gain is zero-extended so it multiplies as a non-negative value. The
  // arithmetic shift floors toward -inf; at full gain the result is exactly
  // data_i, so the low DWIDTH bits never overflow.
  assign product = $signed(data_i) * $signed({1'b0, gain});
  assign scaled  = DWIDTH'(product >>> SHIFT);

  // A press is applied first, so a tick in the same clock steps the gain in
  // the direction of the new state.
  // NOTE: every variable written here gets a default at the top so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_eff   = state;
    state_next  = state;
    gain_next   = gain;
    settle_next = settle_cnt;

    if (press) begin
      case (state)
        BYPASS:          state_eff = SETTLE_ON;
        FADE_IN, ACTIVE: state_eff = FADE_OUT;
        FADE_OUT:        state_eff = FADE_IN;
        default:         state_eff = state;   // settling: press ignored
      endcase
    end
    state_next = state_eff;

    if (sample_tick_i) begin
      case (state_eff)
        SETTLE_ON, SETTLE_OFF: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_next = '0;
            state_next  = (state_eff == SETTLE_ON) ? FADE_IN : BYPASS;
          end else begin
            settle_next = settle_cnt + 1'b1;
          end
        end
        FADE_IN: begin
          if (gain != GAIN_MAX) gain_next = gain + 1'b1;
          if (gain_next == GAIN_MAX) state_next = ACTIVE;
        end
        FADE_OUT: begin
          if (gain != '0) gain_next = gain - 1'b1;
          if (gain_next == '0) state_next = SETTLE_OFF;
        end
        default: ;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they change on the same
  // edge as the state register (relay opens on the edge the gain hits zero).
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= BYPASS;
      gain        <= '0;
      settle_cnt  <= '0;
      data_o      <= '0;
      relay_o     <= 1'b0;
      effect_on_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_next;
      gain        <= gain_next;
      settle_cnt  <= settle_next;
      if (sample_tick_i) data_o <= scaled;   // pre-step gain
      relay_o     <= relay_on(state_next);
      effect_on_o <= (state_next == ACTIVE);
      busy_o      <= is_busy(state_next);
    end
  end

endmodule

// File: tb/tb_bypass_relay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bypass_relay_ctrl
// Self-checking bench: a tick-level reference model pushes the expected
// data_o/relay_o of every sample tick into a scoreboard queue, popped when the
// DUT output is due; state-decoded outputs are compared between ticks.
// -----------------------------------------------------------------------------
module tb_bypass_relay_ctrl;
  import bypass_pkg::*;

  localparam int DW     = 24;
  localparam int RAMP   = 4;
  localparam int SETTLE = 3;
  localparam int DEB    = 2;

  logic          clk_i = 1'b0;
  logic          arst_n_i;
  logic          sample_tick_i;
  logic          button_i;
  logic [DW-1:0] data_i;
  logic [DW-1:0] data_o;
  logic          relay_o;
  logic          effect_on_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  bypass_relay_ctrl #(
    .DWIDTH          (DW),
    .RAMP_SAMPLES    (RAMP),
    .SETTLE_SAMPLES  (SETTLE),
    .DEBOUNCE_SAMPLES(DEB)
  ) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .sample_tick_i(sample_tick_i),
    .button_i     (button_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .relay_o      (relay_o),
    .effect_on_o  (effect_on_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          relay;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model, advanced once per sample tick.
  bypass_state_t m_state;
  int            m_gain;
  int            m_settle;
  bit            m_stable;
  int            m_cnt;
  bit            m_pending;
  bit            m_btn;
  logic [DW-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic m_relay(input bypass_state_t s);
    return s inside {SETTLE_ON, FADE_IN, ACTIVE, FADE_OUT};
  endfunction

  task automatic model_reset();
    m_state   = BYPASS;
    m_gain    = 0;
    m_settle  = 0;
    m_stable  = 1'b1;
    m_cnt     = 0;
    m_pending = 1'b0;
    sb.delete();
  endtask

  task automatic model_press();
    case (m_state)
      BYPASS:          m_state = SETTLE_ON;
      FADE_IN, ACTIVE: m_state = FADE_OUT;
      FADE_OUT:        m_state = FADE_IN;
      default: ;
    endcase
    m_pending = 1'b0;
  endtask

  task automatic model_tick();
    exp_t   e;
    longint p;
    if (m_pending) model_press();
    p      = longint'($signed(m_data)) * m_gain;
    e.data = DW'(p >>> $clog2(RAMP));
    case (m_state)
      SETTLE_ON, SETTLE_OFF: begin
        m_settle++;
        if (m_settle == SETTLE) begin
          m_settle = 0;
          m_state  = (m_state == SETTLE_ON) ? FADE_IN : BYPASS;
        end
      end
      FADE_IN: begin
        if (m_gain < RAMP) m_gain++;
        if (m_gain == RAMP) m_state = ACTIVE;
      end
      FADE_OUT: begin
        if (m_gain > 0) m_gain--;
        if (m_gain == 0) m_state = SETTLE_OFF;
      end
      default: ;
    endcase
    e.relay = m_relay(m_state);
    sb.push_back(e);
    if (m_btn != m_stable) begin
      m_cnt++;
      if (m_cnt == DEB) begin
        m_stable = m_btn;
        m_cnt    = 0;
        if (!m_btn) m_pending = 1'b1;
      end
    end else begin
      m_cnt = 0;
    end
  endtask

  task automatic compare_tick();
    exp_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("data_o", data_o, e.data);
      check("relay_at_tick", relay_o, e.relay);
    end
  endtask

  // `burst` back-to-back tick clocks, then idle out an 8-clock sample period
  // and compare the state-decoded outputs once any pending press has landed.
  task automatic tick(input int burst);
    for (int i = 0; i < burst; i++) begin
      @(negedge clk_i);
      if (i > 0) compare_tick();
      sample_tick_i = 1'b1;
      model_tick();
    end
    @(negedge clk_i);
    sample_tick_i = 1'b0;
    compare_tick();
    repeat (6) @(negedge clk_i);
    if (m_pending) model_press();
    check("relay_o", relay_o, m_relay(m_state));
    check("effect_on_o", effect_on_o, m_state == ACTIVE);
    check("busy_o", busy_o, (m_state != BYPASS) && (m_state != ACTIVE));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1);
  endtask

  task automatic set_btn(input bit v);
    @(negedge clk_i);
    button_i = v;
    m_btn    = v;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic set_data(input logic [DW-1:0] v);
    @(negedge clk_i);
    data_i = v;
    m_data = v;
  endtask

  // Debounced press: hold low for DEB ticks, release, let the release settle.
  task automatic press_and_release(input int ticks_after);
    set_btn(1'b0);
    ticks(DEB);
    set_btn(1'b1);
    ticks(ticks_after);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    arst_n_i      = 1'b0;
    sample_tick_i = 1'b0;
    button_i      = 1'b1;
    m_btn         = 1'b1;
    data_i        = 24'h100000;
    m_data        = 24'h100000;
    model_reset();
    #1;
    check("rst_data_o", data_o, 0);
    check("rst_relay_o", relay_o, 0);
    check("rst_effect_on_o", effect_on_o, 0);
    check("rst_busy_o", busy_o, 0);
    repeat (3) @(negedge clk_i);
    arst_n_i = 1'b1;

    // Idle: nothing may move.
    ticks(20);

    // One-tick glitch is rejected.
    set_btn(1'b0);
    ticks(1);
    set_btn(1'b1);
    ticks(3);

    // Engage: settle, then 0x040000..0x100000 ramp into ACTIVE.
    press_and_release(10);

    // Negative data fade-out down to BYPASS.
    set_data(24'hF00000);
    ticks(1);
    press_and_release(8);

    // Engage again, fade out, and land a second press in SETTLE_OFF (ignored).
    set_data(24'h100000);
    press_and_release(10);
    set_btn(1'b0);
    ticks(DEB);
    set_btn(1'b1);
    ticks(2);
    press_and_release(5);

    // Reverse during FADE_IN: press from BYPASS, second press at gain 1.
    set_btn(1'b0);
    ticks(DEB);
    set_btn(1'b1);
    ticks(2);
    press_and_release(6);

    // Press coinciding with a sample tick (back-to-back strobes).
    set_btn(1'b0);
    ticks(1);
    tick(2);
    set_btn(1'b1);
    ticks(10);

    // Back to BYPASS, then engage and reset asynchronously mid fade-in.
    press_and_release(8);
    press_and_release(5);
    check("pre_rst_gain_nonzero", data_o, 24'h040000);
    @(negedge clk_i);
    #2 arst_n_i = 1'b0;
    #1;
    check("async_rst_data_o", data_o, 0);
    check("async_rst_relay_o", relay_o, 0);
    check("async_rst_effect_on_o", effect_on_o, 0);
    check("async_rst_busy_o", busy_o, 0);
    model_reset();
    repeat (3) @(negedge clk_i);
    arst_n_i = 1'b1;
    ticks(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
